read_32bit_from_ip_ram: RTL and testbench



---
 rtl/mem_pkg.sv | 24 ++
 rtl/rd_tag_pipe.sv | 38 +++
 rtl/read_32bit_from_ip_ram.sv | 165 ++++++++++++++++
 tb/tb_read_32bit_from_ip_ram.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared memory-stage definitions for the IP RAM load path.
package mem_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 19;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef logic [1:0] byte_lane_t;

  // Load FSM encoding, kept as plain constants for legacy tool flows.
  typedef logic [1:0] rd_state_t;
  localparam rd_state_t IDLE  = 2'd0;
  localparam rd_state_t ISSUE = 2'd1;
  localparam rd_state_t DRAIN = 2'd2;
  localparam rd_state_t DONE  = 2'd3;

  // Travels alongside each RAM request so the returning byte knows its lane.
  typedef struct packed {
    logic       valid;
    byte_lane_t lane;
  } rd_tag_t;

  localparam byte_lane_t LAST_LANE = byte_lane_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/rd_tag_pipe.sv
// Delay line matching the RAM read latency; a tag pushed with a request
// appears at tag_out on the edge where its byte is on ram_readdata.
module rd_tag_pipe
  import mem_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic    clk,
  input  logic    rst_n,
  input  rd_tag_t tag_in,
  output rd_tag_t tag_out
);

  rd_tag_t pipe_q [RD_LATENCY];
  rd_tag_t pipe_d [RD_LATENCY];

  // Shift one stage per cycle.
  always_comb begin
    pipe_d[0] = tag_in;
    for (int i = 1; i < int'(RD_LATENCY); i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Reset discards every in-flight tag so late RAM returns are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(RD_LATENCY); i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[RD_LATENCY-1];

endmodule

// File: rtl/read_32bit_from_ip_ram.sv
// 32-bit little-endian load from the byte-wide IP RAM.
// Four byte reads are issued back-to-back; returning bytes are steered to
// their lane by a tag pipe and the full word is published with a done pulse.
// Optional macro READ_ALIGN_CHECK_EN: adds a misaligned output and rejects
// starts whose address is not word aligned without touching the RAM.
// RD_LATENCY legal range is 1..4.
module read_32bit_from_ip_ram
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEFAULT_ADDR_W,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic [31:0]       data_out,
`ifdef READ_ALIGN_CHECK_EN
  output logic              misaligned,
`endif
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_read_enable,
  input  logic [7:0]        ram_readdata
);

  rd_state_t         state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  byte_lane_t        k_q, k_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] ram_address_q, ram_address_d;
  logic              ram_read_enable_q, ram_read_enable_d;
  byte_lane_t        issue_lane;
  rd_tag_t           tag_in, tag_out;
`ifdef READ_ALIGN_CHECK_EN
  logic              misaligned_q, misaligned_d;
`endif

  rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_tag_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

  // Next-state: request issue, byte assembly and word publication.
  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    k_d               = k_q;
    busy_d            = busy_q;
    done_d            = 1'b0;
    data_out_d        = data_out_q;
    ram_address_d     = ram_address_q;
    ram_read_enable_d = 1'b0;
    issue_lane        = '0;
`ifdef READ_ALIGN_CHECK_EN
    misaligned_d      = 1'b0;
`endif

    asm_d = asm_q;
    if (tag_out.valid) begin
      asm_d[{tag_out.lane, 3'b000} +: 8] = ram_readdata;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          base_d = address;
          busy_d = 1'b1;
`ifdef READ_ALIGN_CHECK_EN
          if (address[1:0] != 2'b00) begin
            state_d      = DONE;
            done_d       = 1'b1;
            misaligned_d = 1'b1;
          end else
`endif
          begin
            asm_d             = '0;
            ram_address_d     = address;
            ram_read_enable_d = 1'b1;
            issue_lane        = '0;
            k_d               = 2'd1;
            state_d           = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Address wraps modulo 2^ADDR_W at the top of RAM.
        ram_address_d     = base_q + ADDR_W'(k_q);
        ram_read_enable_d = 1'b1;
        issue_lane        = k_q;
        k_d               = k_q + 2'd1;
        if (k_q == LAST_LANE) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        // The last lane's capture edge publishes the complete word.
        if (tag_out.valid && (tag_out.lane == LAST_LANE)) begin
          data_out_d = asm_d;
          done_d     = 1'b1;
          state_d    = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    tag_in.valid = ram_read_enable_d;
    tag_in.lane  = issue_lane;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      base_q            <= '0;
      k_q               <= '0;
      asm_q             <= '0;
      data_out_q        <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      ram_address_q     <= '0;
      ram_read_enable_q <= 1'b0;
`ifdef READ_ALIGN_CHECK_EN
      misaligned_q      <= 1'b0;
`endif
    end else begin
      state_q           <= state_d;
      base_q            <= base_d;
      k_q               <= k_d;
      asm_q             <= asm_d;
      data_out_q        <= data_out_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      ram_address_q     <= ram_address_d;
      ram_read_enable_q <= ram_read_enable_d;
`ifdef READ_ALIGN_CHECK_EN
      misaligned_q      <= misaligned_d;
`endif
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign data_out        = data_out_q;
  assign ram_address     = ram_address_q;
  assign ram_read_enable = ram_read_enable_q;
`ifdef READ_ALIGN_CHECK_EN
  assign misaligned      = misaligned_q;
`endif

endmodule

// File: tb/tb_read_32bit_from_ip_ram.sv
// Bench for read_32bit_from_ip_ram: table of word reads plus hand-written
// sequences for held start, reset during drain and (optional) misalignment.
module tb_read_32bit_from_ip_ram;

  parameter int RD_LAT = 2;
  localparam int AW = 19;
  localparam int HistIdx = (RD_LAT >= 2) ? RD_LAT - 2 : 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] address;
  logic          busy;
  logic          done;
  logic [31:0]   data_out;
  logic [AW-1:0] ram_address;
  logic          ram_read_enable;
  logic [7:0]    ram_readdata;
`ifdef READ_ALIGN_CHECK_EN
  logic          misaligned;
`endif

  read_32bit_from_ip_ram #(
    .ADDR_W    (AW),
    .RD_LATENCY(RD_LAT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .address        (address),
    .busy           (busy),
    .done           (done),
    .data_out       (data_out),
`ifdef READ_ALIGN_CHECK_EN
    .misaligned     (misaligned),
`endif
    .ram_address    (ram_address),
    .ram_read_enable(ram_read_enable),
    .ram_readdata   (ram_readdata)
  );

  always #5 clk = ~clk;

  // RAM model: data for a request registered at edge E is on the bus for edge E+RD_LAT.
  logic [7:0]    mem [0:(1<<AW)-1];
  logic [AW-1:0] hist_a [4];
  logic          hist_e [4];
  logic [AW-1:0] rd_addr;
  logic          rd_en;

  always @(posedge clk) begin
    hist_a[0] <= ram_address;
    hist_e[0] <= ram_read_enable;
    for (int i = 1; i < 4; i++) begin
      hist_a[i] <= hist_a[i-1];
      hist_e[i] <= hist_e[i-1];
    end
  end

  always_comb begin
    if (RD_LAT == 1) begin
      rd_addr = ram_address;
      rd_en   = ram_read_enable;
    end else begin
      rd_addr = hist_a[HistIdx];
      rd_en   = hist_e[HistIdx];
    end
  end

  assign ram_readdata = rd_en ? mem[rd_addr] : 8'hEE;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Scoreboard of outstanding reads.
  typedef struct {
    logic [31:0] word;
    int          accept;
    int          lat;
    logic        mis;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_done) chk("done_one_cycle", 32'(done), 32'd0);
      if (done) begin
        done_cnt++;
        chk("sb_nonempty_at_done", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("data_out", data_out, e.word);
          chk("done_latency", 32'(cyc - e.accept), 32'(e.lat));
`ifdef READ_ALIGN_CHECK_EN
          chk("misaligned", 32'(misaligned), 32'(e.mis));
`endif
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   word;
  } vec_t;
  vec_t vecs[5];

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || done) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(busy || done), 32'd0);
  endtask

  task automatic wait_sb_empty();
    int n = 0;
    #1;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Issue one read; checks the four issued addresses. Returns at the
  // negedge after the last issue edge.
  task automatic start_read(input logic [AW-1:0] addr, input logic hold, input logic push,
                            input logic [31:0] word);
    logic [AW-1:0] ea;
    wait_idle();
    start   = 1'b1;
    address = addr;
    if (push) sb.push_back('{word: word, accept: cyc + 1, lat: 3 + RD_LAT, mis: 1'b0});
    @(posedge clk);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      ea = addr + AW'(j);
      chk($sformatf("ram_address%0d@%h", j, addr), 32'(ram_address), 32'(ea));
      chk($sformatf("ram_read_enable%0d", j), 32'(ram_read_enable), 32'd1);
      if (j == 0) begin
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (!hold) start = 1'b0;
        address = addr ^ 19'h15A5A;
      end
    end
  endtask

  int dc0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{19'h00100, 8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211};
    vecs[1] = '{19'h00200, 8'hde, 8'had, 8'hbe, 8'hef, 32'hefbeadde};
    vecs[2] = '{19'h7FFFE, 8'ha1, 8'hb2, 8'hc3, 8'hd4, 32'hd4c3b2a1};
    vecs[3] = '{19'h12345, 8'h01, 8'h80, 8'h7f, 8'hfe, 32'hfe7f8001};
    vecs[4] = '{19'h00204, 8'hff, 8'h00, 8'hff, 8'h00, 32'h00ff00ff};
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i * 7 + 3);
    foreach (vecs[v]) begin
      mem[vecs[v].addr]          = vecs[v].b0;
      mem[vecs[v].addr + AW'(1)] = vecs[v].b1;
      mem[vecs[v].addr + AW'(2)] = vecs[v].b2;
      mem[vecs[v].addr + AW'(3)] = vecs[v].b3;
    end

    rst_n   = 1'b0;
    start   = 1'b0;
    address = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_data_out", data_out, 32'd0);
    chk("rst_ram_address", 32'(ram_address), 32'd0);
    chk("rst_ram_read_enable", 32'(ram_read_enable), 32'd0);
`ifdef READ_ALIGN_CHECK_EN
    chk("rst_misaligned", 32'(misaligned), 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven reads, including the top-of-RAM wrap.
    foreach (vecs[v]) begin
`ifdef READ_ALIGN_CHECK_EN
      if (vecs[v].addr[1:0] != 2'b00) continue;
`endif
      start_read(vecs[v].addr, 1'b0, 1'b1, vecs[v].word);
      wait_sb_empty();
    end

    // Reset asserted during DRAIN: immediate clear, no done.
    start_read(19'h00100, 1'b0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_data_out", data_out, 32'd0);
    chk("midrst_ram_address", 32'(ram_address), 32'd0);
    chk("midrst_ram_read_enable", 32'(ram_read_enable), 32'd0);
    dc0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("midrst_no_done", 32'(done_cnt - dc0), 32'd0);
    start_read(19'h00200, 1'b0, 1'b1, 32'hefbeadde);
    wait_sb_empty();

    // start held high with address changed after acceptance.
    dc0 = done_cnt;
    start_read(19'h00100, 1'b1, 1'b1, 32'h44332211);
    address = 19'h00200;
    repeat (1 + RD_LAT) @(negedge clk);
    chk("held_one_done", 32'(done_cnt - dc0), 32'd1);
    chk("held_idle_gap_busy", 32'(busy), 32'd0);
    sb.push_back('{word: 32'hefbeadde, accept: cyc + 1, lat: 3 + RD_LAT, mis: 1'b0});
    @(negedge clk);
    chk("held_restart_busy", 32'(busy), 32'd1);
    chk("held_restart_addr", 32'(ram_address), 32'h00200);
    start = 1'b0;
    wait_sb_empty();

`ifdef READ_ALIGN_CHECK_EN
    // Misaligned start: no RAM traffic, immediate done, data_out unchanged.
    wait_idle();
    start   = 1'b1;
    address = 19'h00101;
    sb.push_back('{word: 32'hefbeadde, accept: cyc + 1, lat: 0, mis: 1'b1});
    @(posedge clk);
    @(negedge clk);
    chk("mis_no_read_enable", 32'(ram_read_enable), 32'd0);
    start = 1'b0;
    @(negedge clk);
    #1;
    chk("mis_clears", 32'(misaligned), 32'd0);
    chk("mis_no_read_enable2", 32'(ram_read_enable), 32'd0);
    wait_sb_empty();
    start_read(19'h00100, 1'b0, 1'b1, 32'h44332211);
    wait_sb_empty();
`endif

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
